// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU input sequencer: FSM state encoding and the ALU
// opcode map used by the ALU, the sequencer and the bench.
package alu_seq_pkg;

  localparam int unsigned StateWidth = 3;

  // Encoding is visible on the debug LEDs, so values are fixed explicitly.
  typedef enum logic [StateWidth-1:0] {
    StWaitA  = 3'd0,
    StWaitB  = 3'd1,
    StWaitOp = 3'd2,
    StExec   = 3'd3,
    StShow   = 3'd4
  } state_e;

  localparam logic [5:0] OpAdd = 6'h20;
  localparam logic [5:0] OpSub = 6'h22;
  localparam logic [5:0] OpAnd = 6'h24;
  localparam logic [5:0] OpOr  = 6'h25;
  localparam logic [5:0] OpXor = 6'h26;
  localparam logic [5:0] OpSrl = 6'h02;
  localparam logic [5:0] OpSra = 6'h03;
  localparam logic [5:0] OpNor = 6'h27;

  // States in which a load-A press starts a new operand sequence.
  function automatic logic accepts_load_a(state_e s);
    return (s == StWaitA) || (s == StShow);
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Button front end: two-flop synchronizer followed by a rising-edge detector.
// A held level produces a single one-cycle pulse, asserted two edges after the
// level is first sampled, so the consumer acts on the third edge.
module btn_edge_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  // Synchronize the asynchronous level and remember its previous value.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_pulse = r_sync2 & ~r_prev;

endmodule

// File: rtl/alu_input_sequencer.sv
// Front-end controller for the 8-bit combinational ALU: captures operand A,
// operand B and the opcode from the switches in strict button order, feeds the
// ALU from registers and latches its result for the LEDs.
// Optional feature macro: ALU_SEQ_FLAGS_EN adds registered o_zero / o_neg flags.
// NB_DATA must be >= NB_OPCODE since the opcode is taken from the low switch bits.
module alu_input_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned NB_DATA   = 8,
  parameter int unsigned NB_OPCODE = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NB_DATA-1:0]   i_sw,
  input  logic                 i_btn_a,
  input  logic                 i_btn_b,
  input  logic                 i_btn_op,
  output logic [NB_DATA-1:0]   o_alu_op_1,
  output logic [NB_DATA-1:0]   o_alu_op_2,
  output logic [NB_OPCODE-1:0] o_alu_opcode,
  input  logic [NB_DATA-1:0]   i_alu_result,
  output logic [NB_DATA-1:0]   o_result,
  output logic                 o_result_valid,
  output logic [2:0]           o_state
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic                 o_zero,
  output logic                 o_neg
`endif
);

  logic w_pulse_a;
  logic w_pulse_b;
  logic w_pulse_op;

  state_e               r_state;
  state_e               w_state_next;
  logic [NB_DATA-1:0]   r_a;
  logic [NB_DATA-1:0]   w_a_next;
  logic [NB_DATA-1:0]   r_b;
  logic [NB_DATA-1:0]   w_b_next;
  logic [NB_OPCODE-1:0] r_op;
  logic [NB_OPCODE-1:0] w_op_next;
  logic [NB_DATA-1:0]   r_result;
  logic [NB_DATA-1:0]   w_result_next;
  logic                 r_valid;
  logic                 w_valid_next;

  btn_edge_detect u_edge_a (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_a),
    .o_pulse (w_pulse_a)
  );

  btn_edge_detect u_edge_b (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_b),
    .o_pulse (w_pulse_b)
  );

  btn_edge_detect u_edge_op (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn   (i_btn_op),
    .o_pulse (w_pulse_op)
  );

  // State and operand/result registers; reset discards any partial sequence.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state  <= StWaitA;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_a      <= w_a_next;
      r_b      <= w_b_next;
      r_op     <= w_op_next;
      r_result <= w_result_next;
      r_valid  <= w_valid_next;
    end
  end

  // Next-state logic: only the pulse matching the current state is honoured,
  // other pulses are dropped rather than queued.
  always_comb begin
    w_state_next  = r_state;
    w_a_next      = r_a;
    w_b_next      = r_b;
    w_op_next     = r_op;
    w_result_next = r_result;
    w_valid_next  = r_valid;
    unique case (r_state)
      StWaitA, StShow: begin
        if (w_pulse_a && accepts_load_a(r_state)) begin
          w_a_next     = i_sw;
          w_valid_next = 1'b0;
          w_state_next = StWaitB;
        end
      end
      StWaitB: begin
        if (w_pulse_b) begin
          w_b_next     = i_sw;
          w_state_next = StWaitOp;
        end
      end
      StWaitOp: begin
        if (w_pulse_op) begin
          w_op_next    = i_sw[NB_OPCODE-1:0];
          w_state_next = StExec;
        end
      end
      StExec: begin
        // ALU has had a full cycle to settle on the freshly loaded opcode.
        w_result_next = i_alu_result;
        w_valid_next  = 1'b1;
        w_state_next  = StShow;
      end
      default: begin
        w_state_next = StWaitA;
      end
    endcase
  end

`ifdef ALU_SEQ_FLAGS_EN
  logic r_zero;
  logic r_neg;

  // Flags are captured together with the result so they always describe o_result.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
    end else if (r_state == StExec) begin
      r_zero <= (i_alu_result == '0);
      r_neg  <= i_alu_result[NB_DATA-1];
    end
  end

  assign o_zero = r_zero;
  assign o_neg  = r_neg;
`else
  // Flags disabled: no extra registers or ports.
`endif

  assign o_alu_op_1     = r_a;
  assign o_alu_op_2     = r_b;
  assign o_alu_opcode   = r_op;
  assign o_result       = r_result;
  assign o_result_valid = r_valid;
  assign o_state        = r_state;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Directed bench for alu_input_sequencer with a behavioural ALU on the result path.
// Define ALU_SEQ_FLAGS_EN for both bench and RTL to exercise the flag outputs.
module tb_alu_input_sequencer;
  import alu_seq_pkg::*;

  localparam int unsigned NbData   = 8;
  localparam int unsigned NbOpcode = 6;

  logic                clk;
  logic                rst_n;
  logic [NbData-1:0]   sw;
  logic                btn_a;
  logic                btn_b;
  logic                btn_op;
  logic [NbData-1:0]   alu_op_1;
  logic [NbData-1:0]   alu_op_2;
  logic [NbOpcode-1:0] alu_opcode;
  logic [NbData-1:0]   alu_result;
  logic [NbData-1:0]   result;
  logic                result_valid;
  logic [2:0]          state;
`ifdef ALU_SEQ_FLAGS_EN
  logic                zero;
  logic                neg;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  alu_input_sequencer #(
    .NB_DATA   (NbData),
    .NB_OPCODE (NbOpcode)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_sw           (sw),
    .i_btn_a        (btn_a),
    .i_btn_b        (btn_b),
    .i_btn_op       (btn_op),
    .o_alu_op_1     (alu_op_1),
    .o_alu_op_2     (alu_op_2),
    .o_alu_opcode   (alu_opcode),
    .i_alu_result   (alu_result),
    .o_result       (result),
    .o_result_valid (result_valid),
    .o_state        (state)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .o_zero         (zero),
    .o_neg          (neg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational ALU; unsupported opcodes give 0.
  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      OpAdd: alu_result = alu_op_1 + alu_op_2;
      OpSub: alu_result = alu_op_1 - alu_op_2;
      OpAnd: alu_result = alu_op_1 & alu_op_2;
      OpOr:  alu_result = alu_op_1 | alu_op_2;
      OpXor: alu_result = alu_op_1 ^ alu_op_2;
      OpSrl: alu_result = alu_op_1 >> alu_op_2;
      OpSra: alu_result = $unsigned($signed(alu_op_1) >>> alu_op_2);
      OpNor: alu_result = ~(alu_op_1 | alu_op_2);
      default: alu_result = '0;
    endcase
  end

  // Stimulus: 0=A, 1=B, 2=OP. Holds the level 4 edges (load happens on the 3rd),
  // releases, then lets the synchronizers drain.
  task automatic press(input int which, input logic [7:0] val);
    @(posedge clk); #1;
    sw = val;
    if (which == 0) btn_a = 1'b1;
    else if (which == 1) btn_b = 1'b1;
    else btn_op = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    btn_a = 1'b0; btn_b = 1'b0; btn_op = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++; if (state !== 3'd0) begin
      n_fail++; $display("FAIL reset_state got %0d want 0", state); end
    n_cmp++; if (result !== 8'h00 || result_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_result got %h/%b want 00/0", result, result_valid); end
    n_cmp++; if (alu_op_1 !== 8'h00 || alu_op_2 !== 8'h00 || alu_opcode !== 6'h00) begin
      n_fail++;
      $display("FAIL reset_regs got %h %h %h want 00 00 00", alu_op_1, alu_op_2, alu_opcode);
    end
  endtask

  task automatic test_add();
    press(0, 8'h05);
    press(1, 8'h03);
    n_cmp++; if (alu_op_1 !== 8'h05 || alu_op_2 !== 8'h03 || state !== 3'd2) begin
      n_fail++;
      $display("FAIL add_operands got %h %h st%0d want 05 03 st2", alu_op_1, alu_op_2, state);
    end
    // Opcode press with explicit edge counting to check latency.
    @(posedge clk); #1;
    sw = 8'h20; btn_op = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (state !== 3'd3 || result_valid !== 1'b0 || alu_opcode !== 6'h20) begin
      n_fail++;
      $display("FAIL add_exec got st%0d v%b op%h want st3 v0 op20", state, result_valid,
               alu_opcode);
    end
    @(negedge clk);
    n_cmp++; if (result !== 8'h08 || result_valid !== 1'b1 || state !== 3'd4) begin
      n_fail++;
      $display("FAIL add_result got %h v%b st%0d want 08 v1 st4", result, result_valid, state);
    end
    #1; btn_op = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_new_from_show();
    press(0, 8'hF0);
    n_cmp++; if (result_valid !== 1'b0 || alu_op_1 !== 8'hF0 || state !== 3'd1) begin
      n_fail++;
      $display("FAIL show_reload got v%b A%h st%0d want v0 AF0 st1", result_valid, alu_op_1,
               state);
    end
    press(1, 8'h01);
    n_cmp++; if (result !== 8'h08) begin
      n_fail++; $display("FAIL show_hold got %h want 08", result); end
    press(2, 8'h20);
    n_cmp++; if (result !== 8'hF1 || result_valid !== 1'b1) begin
      n_fail++; $display("FAIL show_next got %h v%b want F1 v1", result, result_valid); end
  endtask

  task automatic test_sub();
    press(0, 8'h03); press(1, 8'h05); press(2, 8'h22);
    n_cmp++; if (result !== 8'hFE || result_valid !== 1'b1) begin
      n_fail++; $display("FAIL sub_neg got %h v%b want FE v1", result, result_valid); end
`ifdef ALU_SEQ_FLAGS_EN
    n_cmp++; if (neg !== 1'b1 || zero !== 1'b0) begin
      n_fail++; $display("FAIL sub_neg_flags got n%b z%b want n1 z0", neg, zero); end
`endif
    press(0, 8'h07); press(1, 8'h07); press(2, 8'h22);
    n_cmp++; if (result !== 8'h00 || result_valid !== 1'b1) begin
      n_fail++; $display("FAIL sub_zero got %h v%b want 00 v1", result, result_valid); end
`ifdef ALU_SEQ_FLAGS_EN
    n_cmp++; if (neg !== 1'b0 || zero !== 1'b1) begin
      n_fail++; $display("FAIL sub_zero_flags got n%b z%b want n0 z1", neg, zero); end
`endif
  endtask

  task automatic test_out_of_order();
    do_reset();
    press(1, 8'h55);
    press(2, 8'h22);
    n_cmp++; if (state !== 3'd0 || alu_op_2 !== 8'h00 || alu_opcode !== 6'h00) begin
      n_fail++;
      $display("FAIL ooo_ignored got st%0d B%h op%h want st0 B00 op00", state, alu_op_2,
               alu_opcode);
    end
    // Hold A for 100 cycles; a second load would pick up the changed switches.
    @(posedge clk); #1;
    sw = 8'h11; btn_a = 1'b1;
    repeat (10) @(posedge clk);
    #1; sw = 8'h99;
    repeat (90) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (alu_op_1 !== 8'h11 || state !== 3'd1) begin
      n_fail++; $display("FAIL held_a got A%h st%0d want A11 st1", alu_op_1, state); end
    #1; btn_a = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (state !== 3'd1) begin
      n_fail++; $display("FAIL held_a_release got st%0d want 1", state); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press(0, 8'h11); press(1, 8'h22);
    n_cmp++; if (state !== 3'd2) begin
      n_fail++; $display("FAIL mid_setup got st%0d want 2", state); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (state !== 3'd0 || alu_op_1 !== 8'h00 || alu_op_2 !== 8'h00 ||
                 alu_opcode !== 6'h00 || result !== 8'h00 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset got st%0d %h %h %h %h v%b want all 0", state, alu_op_1,
               alu_op_2, alu_opcode, result, result_valid);
    end
    press(2, 8'h20);
    n_cmp++; if (state !== 3'd0 || alu_opcode !== 6'h00) begin
      n_fail++; $display("FAIL mid_op_ignored got st%0d op%h want st0 op00", state, alu_opcode);
    end
  endtask

  task automatic test_unsupported();
    press(0, 8'h01); press(1, 8'h01); press(2, 8'h20);
    n_cmp++; if (result !== 8'h02) begin
      n_fail++; $display("FAIL unsup_pre got %h want 02", result); end
    press(0, 8'h12); press(1, 8'h34); press(2, 8'h3F);
    n_cmp++; if (result !== 8'h00 || result_valid !== 1'b1 || alu_opcode !== 6'h3F) begin
      n_fail++;
      $display("FAIL unsup_op got %h v%b op%h want 00 v1 op3F", result, result_valid,
               alu_opcode);
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    sw     = '0;
    btn_a  = 1'b0;
    btn_b  = 1'b0;
    btn_op = 1'b0;
    test_reset();
    test_add();
    test_new_from_show();
    test_sub();
    test_out_of_order();
    test_reset_mid();
    test_unsupported();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
